// File: rtl/sim_mon_pkg.sv
// Shared types and helpers for the end-of-test monitor.
//   state_e   : monitor FSM states
//   verdict_e : held verdict code (NONE until a decision is made)
//   sat_add   : saturating add at a caller-chosen width (<= 64 bits)
package sim_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        V_NONE,
        V_PASS,
        V_FAIL,
        V_TIMEOUT,
        V_HANG
    } verdict_e;

    localparam int unsigned TOHOST_PASS = 1;

    // Result clamps at the all-ones value of a w-bit counter instead of wrapping.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [63:0] max_v;
        logic [63:0] sum;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        sum   = a + b;
        if ((sum < a) || (sum > max_v)) begin
            return max_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/sim_test_monitor_if.sv
// Bus bundle between the core/bench and the monitor.
//   Inputs to monitor : start, dmem_we, dmem_addr, dmem_wdata, retire_valid
//   Outputs           : done, pass, fail, timeout, hang, fail_id,
//                       cycle_cnt, instret_cnt
// master = side that drives the core signals, slave = the monitor.
interface sim_test_monitor_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NRET   = 1,
    parameter int unsigned CNT_W  = 32
);
    logic              start;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [NRET-1:0]   retire_valid;

    logic              done;
    logic              pass;
    logic              fail;
    logic              timeout;
    logic              hang;
    logic [DATA_W-2:0] fail_id;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  instret_cnt;

    modport master (
        output start, dmem_we, dmem_addr, dmem_wdata, retire_valid,
        input  done, pass, fail, timeout, hang, fail_id, cycle_cnt, instret_cnt
    );

    modport slave (
        input  start, dmem_we, dmem_addr, dmem_wdata, retire_valid,
        output done, pass, fail, timeout, hang, fail_id, cycle_cnt, instret_cnt
    );
endinterface

// File: rtl/retire_popcount.sv
// Counts set bits in the retire strobe vector.
//   retire_valid : NRET strobes
//   count        : number of set strobes, ceil(log2(NRET+1)) bits
module retire_popcount #(
    parameter int unsigned NRET = 1,
    parameter int unsigned PC_W = $clog2(NRET + 1)
) (
    input  logic [NRET-1:0] retire_valid,
    output logic [PC_W-1:0] count
);
    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < NRET; i++) begin
            count = count + PC_W'(retire_valid[i]);
        end
    end
endmodule

// File: rtl/sim_test_monitor.sv
// End-of-test monitor: watches the tohost mailbox and retire strobes,
// decides PASS/FAIL/TIMEOUT/HANG, holds the verdict until rst.
//   clk, rst : clock, synchronous active-high reset
//   mon      : slave side of sim_test_monitor_if (core snoop in, verdict out)
module sim_test_monitor
    import sim_mon_pkg::*;
#(
    parameter int unsigned          ADDR_W         = 32,
    parameter int unsigned          DATA_W         = 32,
    parameter int unsigned          NRET           = 1,
    parameter logic [ADDR_W-1:0]    TOHOST_ADDR    = 32'h0000_1000,
    parameter int unsigned          TIMEOUT_CYCLES = 4096,
    parameter int unsigned          HANG_CYCLES    = 256,
    parameter int unsigned          CNT_W          = 32
) (
    input logic              clk,
    input logic              rst,
    sim_test_monitor_if.slave mon
);
    localparam int unsigned PC_W = $clog2(NRET + 1);

    state_e            state_q, state_d;
    verdict_e          verdict_q, verdict_d;
    logic [DATA_W-2:0] fail_id_q, fail_id_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic [CNT_W-1:0]  idle_q, idle_d;

    logic [PC_W-1:0]   ret_cnt;
    logic              any_ret;
    logic              hit;
    logic [CNT_W-1:0]  cycle_inc, instret_inc, idle_inc;

    retire_popcount #(.NRET(NRET), .PC_W(PC_W)) u_popcount (
        .retire_valid (mon.retire_valid),
        .count        (ret_cnt)
    );

    assign any_ret     = |mon.retire_valid;
    assign hit         = mon.dmem_we && (mon.dmem_addr == TOHOST_ADDR);
    assign cycle_inc   = CNT_W'(sat_add(64'(cycle_q), 64'd1, CNT_W));
    assign instret_inc = CNT_W'(sat_add(64'(instret_q), 64'(ret_cnt), CNT_W));
    assign idle_inc    = CNT_W'(sat_add(64'(idle_q), 64'd1, CNT_W));

    always_comb begin
        state_d   = state_q;
        verdict_d = verdict_q;
        fail_id_d = fail_id_q;
        cycle_d   = cycle_q;
        instret_d = instret_q;
        idle_d    = idle_q;

        case (state_q)
            IDLE: begin
                if (mon.start) begin
                    state_d   = RUN;
                    cycle_d   = '0;
                    instret_d = '0;
                    idle_d    = '0;
                end
            end
            RUN: begin
                // Decision cycle is counted, so counters advance unconditionally.
                cycle_d   = cycle_inc;
                instret_d = instret_inc;
                idle_d    = any_ret ? '0 : idle_inc;

                // An even mailbox write carries no verdict, so the watchdog
                // checks still apply in that cycle.
                if (hit && (mon.dmem_wdata == DATA_W'(TOHOST_PASS))) begin
                    verdict_d = V_PASS;
                    state_d   = DONE;
                end else if (hit && mon.dmem_wdata[0]) begin
                    verdict_d = V_FAIL;
                    fail_id_d = mon.dmem_wdata[DATA_W-1:1];
                    state_d   = DONE;
                end else if ((TIMEOUT_CYCLES != 0) &&
                             (cycle_inc == CNT_W'(TIMEOUT_CYCLES))) begin
                    verdict_d = V_TIMEOUT;
                    state_d   = DONE;
                end else if ((HANG_CYCLES != 0) && !any_ret &&
                             (idle_inc == CNT_W'(HANG_CYCLES))) begin
                    verdict_d = V_HANG;
                    state_d   = DONE;
                end
            end
            DONE: begin
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            verdict_q <= V_NONE;
            fail_id_q <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
            idle_q    <= '0;
        end else begin
            state_q   <= state_d;
            verdict_q <= verdict_d;
            fail_id_q <= fail_id_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            idle_q    <= idle_d;
        end
    end

    assign mon.done        = (verdict_q != V_NONE);
    assign mon.pass        = (verdict_q == V_PASS);
    assign mon.fail        = (verdict_q == V_FAIL);
    assign mon.timeout     = (verdict_q == V_TIMEOUT);
    assign mon.hang        = (verdict_q == V_HANG);
    assign mon.fail_id     = fail_id_q;
    assign mon.cycle_cnt   = cycle_q;
    assign mon.instret_cnt = instret_q;
endmodule

// File: tb/tb_sim_test_monitor.sv
// Directed bench for sim_test_monitor: four instances cover the default
// configuration, a short timeout, dual-issue hang detection and a 4-bit
// saturating counter configuration.
module tb_sim_test_monitor;

    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_d = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    sim_test_monitor_if #(.ADDR_W(32), .DATA_W(32), .NRET(1), .CNT_W(32)) if_a ();
    sim_test_monitor_if #(.ADDR_W(32), .DATA_W(32), .NRET(1), .CNT_W(32)) if_b ();
    sim_test_monitor_if #(.ADDR_W(32), .DATA_W(32), .NRET(2), .CNT_W(32)) if_c ();
    sim_test_monitor_if #(.ADDR_W(32), .DATA_W(32), .NRET(1), .CNT_W(4))  if_d ();

    sim_test_monitor #(.NRET(1), .TIMEOUT_CYCLES(4096), .HANG_CYCLES(256), .CNT_W(32))
        dut_a (.clk(clk), .rst(rst_a), .mon(if_a.slave));
    sim_test_monitor #(.NRET(1), .TIMEOUT_CYCLES(100), .HANG_CYCLES(0), .CNT_W(32))
        dut_b (.clk(clk), .rst(rst_b), .mon(if_b.slave));
    sim_test_monitor #(.NRET(2), .TIMEOUT_CYCLES(4096), .HANG_CYCLES(16), .CNT_W(32))
        dut_c (.clk(clk), .rst(rst_c), .mon(if_c.slave));
    sim_test_monitor #(.NRET(1), .TIMEOUT_CYCLES(0), .HANG_CYCLES(0), .CNT_W(4))
        dut_d (.clk(clk), .rst(rst_d), .mon(if_d.slave));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and samples both sit 1 time unit after posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        if_a.start = 0; if_a.dmem_we = 0; if_a.dmem_addr = '0; if_a.dmem_wdata = '0; if_a.retire_valid = '0;
        if_b.start = 0; if_b.dmem_we = 0; if_b.dmem_addr = '0; if_b.dmem_wdata = '0; if_b.retire_valid = '0;
        if_c.start = 0; if_c.dmem_we = 0; if_c.dmem_addr = '0; if_c.dmem_wdata = '0; if_c.retire_valid = '0;
        if_d.start = 0; if_d.dmem_we = 0; if_d.dmem_addr = '0; if_d.dmem_wdata = '0; if_d.retire_valid = '0;

        // ---------------- Pass at cycle 50 ----------------
        step(); step();
        rst_a = 0; rst_b = 0; rst_c = 0; rst_d = 0;
        check_eq("reset_done", if_a.done, 0);
        check_eq("reset_cycle", if_a.cycle_cnt, 0);
        check_eq("reset_instret", if_a.instret_cnt, 0);
        if_a.start = 1; step(); if_a.start = 0;
        if_a.retire_valid = 1;
        repeat (49) step();
        check_eq("pre_pass_done", if_a.done, 0);
        if_a.dmem_we = 1; if_a.dmem_addr = 32'h1000; if_a.dmem_wdata = 32'h1;
        step();
        if_a.dmem_we = 0; if_a.retire_valid = 0;
        check_eq("pass_done", if_a.done, 1);
        check_eq("pass_pass", if_a.pass, 1);
        check_eq("pass_fail", if_a.fail, 0);
        check_eq("pass_cycle", if_a.cycle_cnt, 50);
        check_eq("pass_instret", if_a.instret_cnt, 50);
        if_a.retire_valid = 1; if_a.start = 1;
        repeat (20) step();
        if_a.retire_valid = 0; if_a.start = 0;
        check_eq("hold_pass", if_a.pass, 1);
        check_eq("hold_cycle", if_a.cycle_cnt, 50);
        check_eq("hold_instret", if_a.instret_cnt, 50);

        // ---------------- Fail with id 3 ----------------
        rst_a = 1; step(); rst_a = 0;
        check_eq("rst_after_done", if_a.done, 0);
        if_a.start = 1; step(); if_a.start = 0;
        repeat (3) step();
        if_a.dmem_we = 1; if_a.dmem_addr = 32'h1000; if_a.dmem_wdata = 32'h7;
        step();
        if_a.dmem_we = 0;
        check_eq("fail_done", if_a.done, 1);
        check_eq("fail_fail", if_a.fail, 1);
        check_eq("fail_id", if_a.fail_id, 3);
        check_eq("fail_pass", if_a.pass, 0);
        check_eq("fail_timeout", if_a.timeout, 0);
        check_eq("fail_hang", if_a.hang, 0);
        check_eq("fail_cycle", if_a.cycle_cnt, 4);

        // ---------------- Ignored writes ----------------
        rst_a = 1; step(); rst_a = 0;
        if_a.start = 1; step(); if_a.start = 0;
        if_a.dmem_we = 1; if_a.dmem_addr = 32'h1000; if_a.dmem_wdata = 32'h4;
        step();
        check_eq("even_ignored", if_a.done, 0);
        if_a.dmem_addr = 32'h1004; if_a.dmem_wdata = 32'h1;
        step();
        check_eq("other_addr_ignored", if_a.done, 0);
        if_a.dmem_addr = 32'h1000; if_a.dmem_wdata = 32'h1;
        step();
        if_a.dmem_we = 0;
        check_eq("late_pass", if_a.pass, 1);
        check_eq("late_pass_cycle", if_a.cycle_cnt, 3);

        // ---------------- Timeout at 100 ----------------
        if_b.start = 1; step(); if_b.start = 0;
        if_b.retire_valid = 1;
        repeat (99) step();
        check_eq("pre_timeout", if_b.done, 0);
        step();
        check_eq("timeout_flag", if_b.timeout, 1);
        check_eq("timeout_pass", if_b.pass, 0);
        check_eq("timeout_cycle", if_b.cycle_cnt, 100);
        check_eq("timeout_instret", if_b.instret_cnt, 100);

        rst_b = 1; step(); rst_b = 0;
        if_b.start = 1; step(); if_b.start = 0;
        repeat (99) step();
        if_b.dmem_we = 1; if_b.dmem_addr = 32'h1000; if_b.dmem_wdata = 32'h1;
        step();
        if_b.dmem_we = 0; if_b.retire_valid = 0;
        check_eq("mailbox_wins_pass", if_b.pass, 1);
        check_eq("mailbox_wins_timeout", if_b.timeout, 0);
        check_eq("mailbox_wins_cycle", if_b.cycle_cnt, 100);

        // ---------------- Dual-issue hang ----------------
        if_c.start = 1; step(); if_c.start = 0;
        if_c.retire_valid = 2'b11;
        repeat (10) step();
        if_c.retire_valid = 2'b00;
        repeat (15) step();
        check_eq("pre_hang", if_c.done, 0);
        step();
        check_eq("hang_flag", if_c.hang, 1);
        check_eq("hang_done", if_c.done, 1);
        check_eq("hang_instret", if_c.instret_cnt, 20);
        check_eq("hang_cycle", if_c.cycle_cnt, 26);

        rst_c = 1; step(); rst_c = 0;
        if_c.start = 1; step(); if_c.start = 0;
        repeat (15) step();
        if_c.retire_valid = 2'b01;
        step();
        if_c.retire_valid = 2'b00;
        check_eq("retire_at_limit_no_hang", if_c.done, 0);
        check_eq("retire_at_limit_instret", if_c.instret_cnt, 1);

        // ---------------- Saturation and reset mid-run ----------------
        if_d.start = 1; step(); if_d.start = 0;
        if_d.retire_valid = 1;
        repeat (20) step();
        check_eq("sat_instret", if_d.instret_cnt, 15);
        check_eq("sat_cycle", if_d.cycle_cnt, 15);
        check_eq("sat_no_verdict", if_d.done, 0);
        rst_d = 1; step(); rst_d = 0;
        check_eq("midrun_rst_cycle", if_d.cycle_cnt, 0);
        check_eq("midrun_rst_instret", if_d.instret_cnt, 0);
        check_eq("midrun_rst_done", if_d.done, 0);
        repeat (2) step();
        check_eq("idle_ignores_retire", if_d.instret_cnt, 0);
        if_d.start = 1; step(); if_d.start = 0;
        repeat (3) step();
        if_d.retire_valid = 0;
        check_eq("rearm_cycle", if_d.cycle_cnt, 3);
        check_eq("rearm_instret", if_d.instret_cnt, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sim_test_monitor.md
Name: sim_test_monitor

Overview:
- Synthesizable end-of-test monitor for the pipelined core; replaces fixed-delay bench termination.
- Snoops data-memory writes for a tohost mailbox and the core's retire strobes.
- Decides PASS/FAIL/TIMEOUT/HANG, holds the verdict, and reports cycle and instruction counts.
- Parametrised in address/data width, retire width (multi-issue cores), and both watchdog limits.

Parameters:
ADDR_W, 32, data-memory address width
DATA_W, 32, data-memory write-data width
NRET, 1, retire strobes per cycle (1..8)
TOHOST_ADDR, 32'h0000_1000, mailbox byte address (ADDR_W bits)
TIMEOUT_CYCLES, 4096, max RUN cycles before TIMEOUT; 0 disables
HANG_CYCLES, 256, max consecutive zero-retire RUN cycles before HANG; 0 disables
CNT_W, 32, width of cycle and instret counters

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  pulse; arms monitor from IDLE
dmem_we  input  1  data-memory write enable
dmem_addr  input  ADDR_W  write address
dmem_wdata  input  DATA_W  write data
retire_valid  input  NRET  one bit per retiring instruction this cycle
done  output  1  verdict reached; sticky until rst
pass  output  1  tohost==1 observed
fail  output  1  odd tohost!=1 observed
timeout  output  1  TIMEOUT_CYCLES exhausted
hang  output  1  HANG_CYCLES without retirement
fail_id  output  DATA_W-1  dmem_wdata[DATA_W-1:1] of the failing write
cycle_cnt  output  CNT_W  RUN cycles elapsed
instret_cnt  output  CNT_W  instructions retired in RUN

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; every output 0; all counters 0. Reset mid-RUN or in DONE returns to IDLE next edge.
- States: IDLE, RUN, DONE.
- IDLE: ignores dmem and retire inputs; start=1 -> RUN next edge with counters cleared. start in RUN/DONE is ignored.
- RUN, each edge, evaluated in priority order:
  1. tohost hit (dmem_we && dmem_addr==TOHOST_ADDR):
     - wdata==1 -> pass.
     - wdata odd and !=1 -> fail, fail_id<=wdata[DATA_W-1:1].
     - wdata even (incl. 0) -> ignored, stay RUN.
  2. Else timeout: cycle_cnt+1==TIMEOUT_CYCLES -> timeout.
  3. Else hang: idle_cnt+1==HANG_CYCLES and retire_valid==0 -> hang.
- A pass/fail/timeout/hang result moves the FSM to DONE and raises done with it; exactly one verdict bit is 1.
- Latency: verdict and done are registered, visible the edge after the triggering cycle.
- Counters (RUN only):
  - cycle_cnt +1 per cycle.
  - instret_cnt += popcount(retire_valid).
  - idle_cnt clears on any retire bit, else +1.
  - All saturate at all-ones; no wrap.
  - The decision cycle is counted.
  - All counters freeze in DONE.
- Simultaneous tohost pass and timeout in the same cycle -> pass (mailbox wins). Retire in the same cycle as the hang limit -> no hang.
- DONE: outputs hold; only rst leaves.
- Width rules: popcount result ceil(log2(NRET+1)) bits, zero-extended to CNT_W before add. Limit compares are done at CNT_W.

Decomposition:
- Package sim_mon_pkg:
  - state enum {IDLE,RUN,DONE}.
  - verdict codes.
  - TOHOST_PASS=1 constant.
  - sat_add helper function.
- Sub-module retire_popcount (NRET in, count out), purely combinational, instantiated once.

Test Plan:
- Pass: rst 2 cycles, start, retire 1/cycle, write 1 to 0x1000 at cycle 50 -> done=pass=1 next edge; cycle_cnt=50, instret_cnt=50; outputs hold 20 more cycles.
- Fail: write 0x0000_0007 to tohost -> fail=1, fail_id=3; pass/timeout/hang=0.
- Ignored write: write 0x4 to tohost then 0x1 to 0x1004 -> still RUN; later write 1 to 0x1000 -> pass.
- Timeout: TIMEOUT_CYCLES=100, HANG_CYCLES=0, continuous retire, no tohost -> timeout=1, cycle_cnt=100. Also tohost=1 on cycle 100 -> pass, not timeout.
- Hang and multi-issue: NRET=2, retire_valid=2'b11 for 10 cycles then 0 with HANG_CYCLES=16 -> hang after 16 idle cycles, instret_cnt=20.
- Reset mid-run and saturation: rst during RUN -> all outputs 0, IDLE, start re-arms. CNT_W=4 with 20 retires -> instret_cnt=15.
